glitc_training_sequencer: RTL

//  Automatic input-alignment controller for the dual-RITC datapath. Masters the datapath register port to select

---
 rtl/glitc_training_sequencer.sv | 287 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/glitc_training_sequencer.sv
// glitc_training_sequencer: per channel/bit IDELAY sweep to find the widest training eye,
// then loads the eye centre and bitslips until DPTRAINING[7:0] equals the training pattern.
module glitc_training_sequencer #(
    parameter logic [7:0] TRAIN_PATTERN = 8'hA5,
    parameter int         SETTLE_CYCLES = 64,
    parameter int         MIN_EYE       = 4,
    parameter int         MAX_SLIPS     = 8
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [5:0]  ch_mask_i,
    output logic        m_sel_o,
    output logic        m_wr_o,
    output logic [3:0]  m_addr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        aborted_o,
    output logic        res_valid_o,
    output logic [6:0]  res_sel_o,
    output logic [4:0]  res_delay_o,
    output logic [5:0]  res_eye_o,
    output logic [3:0]  res_slips_o,
    output logic        res_ok_o,
    output logic [6:0]  fail_count_o
);
    typedef enum logic [3:0] {
        IDLE, ENABLE, SET_DLY, SELECT, SAMPLE, CENTRE, CHECK, SLIP, REPORT, FINISH, WAIT
    } state_t;

    localparam logic [3:0] ADDR_TRAIN  = 4'd2;
    localparam logic [3:0] ADDR_IDELAY = 4'd4;
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [5:0] MIN_EYE_W   = 6'(MIN_EYE);
    localparam logic [3:0] MAX_SLIPS_W = 4'(MAX_SLIPS);

    state_t     state_q, state_d, ret_q, ret_d;
    logic [7:0] cnt_q, cnt_d;
    logic [5:0] mask_q, mask_d;
    logic [2:0] ch_q, ch_d;
    logic [3:0] bit_q, bit_d;
    logic [4:0] tap_q, tap_d;
    logic [4:0] cur_start_q, cur_start_d, best_start_q, best_start_d;
    logic [5:0] cur_len_q, cur_len_d, best_len_q, best_len_d;
    logic [4:0] centre_q, centre_d;
    logic [3:0] slips_q, slips_d;
    logic       match_q, match_d;
    logic       aborted_q, aborted_d;
    logic       res_valid_q, res_valid_d;
    logic [6:0] res_sel_q, res_sel_d;
    logic [4:0] res_delay_q, res_delay_d;
    logic [5:0] res_eye_q, res_eye_d;
    logic [3:0] res_slips_q, res_slips_d;
    logic       res_ok_q, res_ok_d;
    logic [6:0] fail_q, fail_d;

    logic [2:0] first_ch, next_ch;
    logic       first_ok, next_ok;
    logic [6:0] sel;
    logic [5:0] run_len;
    logic [4:0] run_start, centre;
    logic       sample_ok, bit_ok;
    logic       unused_dat;

    function automatic logic is_rotation(input logic [7:0] w);
        logic [15:0] dbl;
        dbl = {TRAIN_PATTERN, TRAIN_PATTERN};
        is_rotation = 1'b0;
        for (int i = 0; i < 8; i++)
            if (dbl[i +: 8] == w) is_rotation = 1'b1;
    endfunction

    assign sel        = {ch_q, bit_q};
    assign unused_dat = ^m_dat_i[31:8];
    assign sample_ok  = is_rotation(m_dat_i[7:0]);
    assign run_len    = cur_len_q + 6'd1;
    assign run_start  = (cur_len_q == 6'd0) ? tap_q : cur_start_q;
    assign centre     = (best_len_q == 6'd0) ? 5'd0 : best_start_q + 5'((best_len_q - 6'd1) >> 1);
    assign bit_ok     = match_q && (best_len_q >= MIN_EYE_W);

    // descending scan so the lowest qualifying channel wins
    always_comb begin
        first_ok = 1'b0;
        first_ch = 3'd0;
        next_ok  = 1'b0;
        next_ch  = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (mask_q[i]) begin
                first_ok = 1'b1;
                first_ch = 3'(i);
            end
            if (mask_q[i] && (3'(i) > ch_q)) begin
                next_ok = 1'b1;
                next_ch = 3'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        cnt_d        = cnt_q;
        mask_d       = mask_q;
        ch_d         = ch_q;
        bit_d        = bit_q;
        tap_d        = tap_q;
        cur_start_d  = cur_start_q;
        cur_len_d    = cur_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
        centre_d     = centre_q;
        slips_d      = slips_q;
        match_d      = match_q;
        aborted_d    = aborted_q;
        res_valid_d  = 1'b0;
        res_sel_d    = res_sel_q;
        res_delay_d  = res_delay_q;
        res_eye_d    = res_eye_q;
        res_slips_d  = res_slips_q;
        res_ok_d     = res_ok_q;
        fail_d       = fail_q;
        m_sel_o      = 1'b0;
        m_wr_o       = 1'b0;
        m_addr_o     = 4'd0;
        m_dat_o      = 32'd0;
        done_o       = 1'b0;
        case (state_q)
            IDLE: if (start_i) begin
                state_d   = ENABLE;
                mask_d    = ch_mask_i;
                fail_d    = 7'd0;
                aborted_d = 1'b0;
            end
            ENABLE: begin
                ch_d    = first_ch;
                bit_d   = 4'd0;
                state_d = first_ok ? SET_DLY : FINISH;
            end
            SET_DLY: begin
                {m_sel_o, m_wr_o, m_addr_o} = {2'b11, ADDR_IDELAY};
                m_dat_o = {1'b1, 8'd0, sel, 11'd0, tap_q};
                {state_d, ret_d, cnt_d} = {WAIT, SELECT, SETTLE_LAST};
            end
            SELECT: begin
                {m_sel_o, m_wr_o, m_addr_o} = {2'b11, ADDR_TRAIN};
                m_dat_o = {1'b0, 1'b0, 7'd0, sel, 16'd0};
                {state_d, ret_d, cnt_d} = {WAIT, SAMPLE, SETTLE_LAST};
            end
            SAMPLE: begin
                {m_sel_o, m_addr_o} = {1'b1, ADDR_TRAIN};
                cur_start_d = run_start;
                cur_len_d   = sample_ok ? run_len : 6'd0;
                if (sample_ok && run_len > best_len_q) begin
                    best_start_d = run_start;
                    best_len_d   = run_len;
                end
                tap_d   = tap_q + 5'd1;
                state_d = (tap_q == 5'd31) ? CENTRE : SET_DLY;
            end
            CENTRE: begin
                {m_sel_o, m_wr_o, m_addr_o} = {2'b11, ADDR_IDELAY};
                m_dat_o  = {1'b1, 8'd0, sel, 11'd0, centre};
                centre_d = centre;
                {state_d, ret_d, cnt_d} = {WAIT, CHECK, SETTLE_LAST};
            end
            CHECK: begin
                {m_sel_o, m_addr_o} = {1'b1, ADDR_TRAIN};
                match_d = (m_dat_i[7:0] == TRAIN_PATTERN);
                state_d = (match_d || slips_q >= MAX_SLIPS_W) ? REPORT : SLIP;
            end
            SLIP: begin
                {m_sel_o, m_wr_o, m_addr_o} = {2'b11, ADDR_TRAIN};
                m_dat_o = {1'b0, 1'b1, 7'd0, sel, 16'd0};
                slips_d = slips_q + 4'd1;
                {state_d, ret_d, cnt_d} = {WAIT, CHECK, SETTLE_LAST};
            end
            REPORT: begin
                res_valid_d = 1'b1;
                res_sel_d   = sel;
                res_delay_d = centre_q;
                res_eye_d   = best_len_q;
                res_slips_d = slips_q;
                res_ok_d    = bit_ok;
                if (!bit_ok && fail_q != 7'd127) fail_d = fail_q + 7'd1;
                if (bit_q != 4'd11) begin
                    bit_d   = bit_q + 4'd1;
                    state_d = SET_DLY;
                end else if (next_ok) begin
                    ch_d    = next_ch;
                    bit_d   = 4'd0;
                    state_d = SET_DLY;
                end else begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                {m_sel_o, m_wr_o, m_addr_o} = {2'b11, ADDR_TRAIN};
                m_dat_o = 32'h8000_0000;
                done_o  = 1'b1;
                state_d = IDLE;
            end
            WAIT: begin
                cnt_d   = cnt_q - 8'd1;
                state_d = (cnt_q == 8'd0) ? ret_q : WAIT;
            end
            default: state_d = IDLE;
        endcase
        // a new bit starts with fresh sweep trackers
        if (state_q == ENABLE || state_q == REPORT) begin
            tap_d        = 5'd0;
            cur_start_d  = 5'd0;
            cur_len_d    = 6'd0;
            best_start_d = 5'd0;
            best_len_d   = 6'd0;
            slips_d      = 4'd0;
            match_d      = 1'b0;
        end
        if (abort_i && state_d != state_q &&
            (state_d == SET_DLY || state_d == SLIP || state_d == REPORT)) begin
            state_d   = FINISH;
            aborted_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            ret_q        <= IDLE;
            cnt_q        <= 8'd0;
            mask_q       <= 6'd0;
            ch_q         <= 3'd0;
            bit_q        <= 4'd0;
            tap_q        <= 5'd0;
            cur_start_q  <= 5'd0;
            cur_len_q    <= 6'd0;
            best_start_q <= 5'd0;
            best_len_q   <= 6'd0;
            centre_q     <= 5'd0;
            slips_q      <= 4'd0;
            match_q      <= 1'b0;
            aborted_q    <= 1'b0;
            res_valid_q  <= 1'b0;
            res_sel_q    <= 7'd0;
            res_delay_q  <= 5'd0;
            res_eye_q    <= 6'd0;
            res_slips_q  <= 4'd0;
            res_ok_q     <= 1'b0;
            fail_q       <= 7'd0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            cnt_q        <= cnt_d;
            mask_q       <= mask_d;
            ch_q         <= ch_d;
            bit_q        <= bit_d;
            tap_q        <= tap_d;
            cur_start_q  <= cur_start_d;
            cur_len_q    <= cur_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
            centre_q     <= centre_d;
            slips_q      <= slips_d;
            match_q      <= match_d;
            aborted_q    <= aborted_d;
            res_valid_q  <= res_valid_d;
            res_sel_q    <= res_sel_d;
            res_delay_q  <= res_delay_d;
            res_eye_q    <= res_eye_d;
            res_slips_q  <= res_slips_d;
            res_ok_q     <= res_ok_d;
            fail_q       <= fail_d;
        end
    end

    assign busy_o       = (state_q != IDLE) && (state_q != FINISH);
    assign aborted_o    = aborted_q;
    assign res_valid_o  = res_valid_q;
    assign res_sel_o    = res_sel_q;
    assign res_delay_o  = res_delay_q;
    assign res_eye_o    = res_eye_q;
    assign res_slips_o  = res_slips_q;
    assign res_ok_o     = res_ok_q;
    assign fail_count_o = fail_q;
endmodule
